riscv_mc_ctrl: RTL

Multi-cycle control sequencer for the basic RISC-V (RV32I subset) core. Fetches each instruction over a valid/ready memory port, decodes the opcode, drives the immediate-format select consumed by the immediate decoder, and steps the shared ALU, register file and memory port through execute, memory and writeback cycles. Sits beside the datapath; it holds only control state, never data.

---
 rtl/riscv_pkg.sv | 51 +++++
 rtl/opcode_class.sv | 55 +++++
 rtl/riscv_mc_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared control encodings for the multi-cycle RV32I core.
// Imported by the sequencer, the opcode decoder and the immediate decoder.
package riscv_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    CL_OP     = 4'd0,
    CL_OPIMM  = 4'd1,
    CL_LUI    = 4'd2,
    CL_AUIPC  = 4'd3,
    CL_LOAD   = 4'd4,
    CL_STORE  = 4'd5,
    CL_JAL    = 4'd6,
    CL_JALR   = 4'd7,
    CL_BRANCH = 4'd8,
    CL_ILL    = 4'd9
  } opc_class_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_U = 3'b010;
  localparam logic [2:0] IMM_J = 3'b100;
  localparam logic [2:0] IMM_B = 3'b101;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_FN    = 2'b01;
  localparam logic [1:0] ALU_PASSB = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

endpackage

// File: rtl/opcode_class.sv
// Combinational opcode classifier: instruction class, immediate
// format and illegal-opcode flag.
module opcode_class
  import riscv_pkg::*;
(
  input  logic [6:0]  i_opcode,
  output opc_class_e  o_cls,
  output logic [2:0]  o_imm_sel,
  output logic        o_illegal
);

  always_comb begin
    o_cls     = CL_ILL;
    o_imm_sel = IMM_I;
    o_illegal = 1'b0;
    unique case (1'b1)
      (i_opcode == OPC_OP): begin
        o_cls = CL_OP;
      end
      (i_opcode == OPC_OPIMM): begin
        o_cls = CL_OPIMM;
      end
      (i_opcode == OPC_LUI): begin
        o_cls     = CL_LUI;
        o_imm_sel = IMM_U;
      end
      (i_opcode == OPC_AUIPC): begin
        o_cls     = CL_AUIPC;
        o_imm_sel = IMM_U;
      end
      (i_opcode == OPC_LOAD): begin
        o_cls = CL_LOAD;
      end
      (i_opcode == OPC_STORE): begin
        o_cls     = CL_STORE;
        o_imm_sel = IMM_S;
      end
      (i_opcode == OPC_JAL): begin
        o_cls     = CL_JAL;
        o_imm_sel = IMM_J;
      end
      (i_opcode == OPC_JALR): begin
        o_cls = CL_JALR;
      end
      (i_opcode == OPC_BRANCH): begin
        o_cls     = CL_BRANCH;
        o_imm_sel = IMM_B;
      end
      default: begin
        o_illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/riscv_mc_ctrl.sv
// Multi-cycle control sequencer: fetch, decode, execute, memory and
// writeback stepping for the shared-datapath RV32I core.
module riscv_mc_ctrl
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  input  logic        br_taken,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic        pc_sel,
  output logic [2:0]  imm_sel,
  output logic        alu_a_sel,
  output logic        alu_b_sel,
  output logic [1:0]  alu_op,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        trap
);

  state_e     r_state;
  state_e     w_next;
  opc_class_e w_cls;
  logic [2:0] w_imm;
  logic       w_ill;
  logic       w_mem_req;
  logic       w_ir_we;
  logic       w_pc_we;
  logic       w_rf_we;
  logic       w_unused;

  assign w_unused = ^ir[31:7];

  opcode_class u_opc (
    .i_opcode  (ir[6:0]),
    .o_cls     (w_cls),
    .o_imm_sel (w_imm),
    .o_illegal (w_ill)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_mem_req = 1'b0;
    w_ir_we   = 1'b0;
    w_pc_we   = 1'b0;
    w_rf_we   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    pc_sel    = 1'b0;
    alu_a_sel = 1'b0;
    alu_b_sel = 1'b0;
    alu_op    = ALU_ADD;
    wb_sel    = WB_ALU;
    unique case (r_state)
      S_FETCH: begin
        w_mem_req = 1'b1;
        if (mem_ready) begin
          w_ir_we = 1'b1;
          w_next  = S_DECODE;
        end
      end
      S_DECODE: begin
        w_next = w_ill ? S_TRAP : S_EXEC;
      end
      S_EXEC: begin
        w_next = S_WB;
        unique case (w_cls)
          CL_OP: begin
            alu_op = ALU_FN;
          end
          CL_OPIMM: begin
            alu_op    = ALU_FN;
            alu_b_sel = 1'b1;
          end
          CL_LUI: begin
            alu_op    = ALU_PASSB;
            alu_b_sel = 1'b1;
          end
          CL_AUIPC: begin
            alu_a_sel = 1'b1;
            alu_b_sel = 1'b1;
          end
          CL_LOAD, CL_STORE: begin
            alu_b_sel = 1'b1;
            w_next    = S_MEM;
          end
          CL_JAL: begin
            alu_a_sel = 1'b1;
            alu_b_sel = 1'b1;
            w_pc_we   = 1'b1;
            pc_sel    = 1'b1;
          end
          CL_JALR: begin
            alu_b_sel = 1'b1;
            w_pc_we   = 1'b1;
            pc_sel    = 1'b1;
          end
          CL_BRANCH: begin
            alu_a_sel = 1'b1;
            alu_b_sel = 1'b1;
            w_pc_we   = 1'b1;
            pc_sel    = br_taken;
            w_next    = S_FETCH;
          end
          default: begin
            w_next = S_TRAP;
          end
        endcase
      end
      S_MEM: begin
        w_mem_req = 1'b1;
        addr_sel  = 1'b1;
        mem_we    = (w_cls == CL_STORE);
        if (mem_ready) begin
          if (w_cls == CL_STORE) begin
            w_pc_we = 1'b1;
            w_next  = S_FETCH;
          end else begin
            w_next = S_WB;
          end
        end
      end
      S_WB: begin
        w_rf_we = 1'b1;
        w_next  = S_FETCH;
        // jumps already redirected the PC in EXEC
        if (w_cls == CL_LOAD) begin
          wb_sel  = WB_MEM;
          w_pc_we = 1'b1;
        end else if (w_cls == CL_JAL || w_cls == CL_JALR) begin
          wb_sel = WB_PC4;
        end else begin
          w_pc_we = 1'b1;
        end
      end
      S_TRAP: begin
        w_next = S_TRAP;
      end
      default: begin
        w_next = S_FETCH;
      end
    endcase
  end

  assign imm_sel = (r_state == S_FETCH || r_state == S_TRAP) ? IMM_I : w_imm;
  assign trap    = (r_state == S_TRAP);

  // enables are forced low while reset is held
  assign mem_req = rst_n & w_mem_req;
  assign ir_we   = rst_n & w_ir_we;
  assign pc_we   = rst_n & w_pc_we;
  assign rf_we   = rst_n & w_rf_we;

endmodule
